// File: rtl/i2c_pkg.sv
// Shared I2C definitions: field widths, operation codes and the bus arbiter state encoding.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    localparam logic OP_READ  = 1'b1;
    localparam logic OP_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_RESP
    } arb_state_e;

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: scans from the requester after last_gnt_i and
// returns the first pending one as both a one-hot vector and an encoded index.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_gnt_i,
    output logic [NUM_REQ-1:0] winner_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] sel;
        winner_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        sel      = '0;
        // Candidate order is last_gnt+1, last_gnt+2, ... wrapping at NUM_REQ.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_gnt_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            sel = IDX_W'(cand);
            if (!any_o && req_i[sel]) begin
                any_o         = 1'b1;
                idx_o         = sel;
                winner_o[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one i2c_master between NUM_REQ requesters with round-robin priority,
// returning read data / ack status to the winner and aborting hung transfers.
module i2c_bus_arbiter
    import i2c_pkg::*;
#(
    parameter int  NUM_REQ        = 2,
    parameter int  TIMEOUT_CYCLES = 20000,
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_op,
    input  logic [I2C_DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [I2C_DATA_W-1:0]         rsp_rdata,
    output logic                          rsp_ack_err,
    output logic                          rsp_timeout,
    output logic                          m_newd,
    output logic [I2C_ADDR_W-1:0]         m_addr,
    output logic                          m_op,
    output logic [I2C_DATA_W-1:0]         m_din,
    input  logic                          m_busy,
    input  logic                          m_done,
    input  logic                          m_ack_err,
    input  logic [I2C_DATA_W-1:0]         m_dout,
    output logic                          fault
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e              state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        last_gnt_q;
    logic [TO_W-1:0]         wd_q;
    logic [TO_W-1:0]         wd_d;
    logic                    wd_expired;
    logic [NUM_REQ-1:0]      gnt_q;
    logic [NUM_REQ-1:0]      rsp_valid_q;
    logic [I2C_DATA_W-1:0]   rsp_rdata_q;
    logic                    rsp_ack_err_q;
    logic                    rsp_timeout_q;
    logic                    m_newd_q;
    logic [I2C_ADDR_W-1:0]   m_addr_q;
    logic                    m_op_q;
    logic [I2C_DATA_W-1:0]   m_din_q;
    logic                    fault_q;

    logic [NUM_REQ-1:0]      pick_winner;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i      (req),
        .last_gnt_i (last_gnt_q),
        .winner_o   (pick_winner),
        .idx_o      (pick_idx),
        .any_o      (pick_any)
    );

    assign wd_d       = wd_q + TO_W'(1);
    assign wd_expired = (wd_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            last_gnt_q    <= IDX_W'(NUM_REQ - 1);
            wd_q          <= '0;
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_ack_err_q <= 1'b0;
            rsp_timeout_q <= 1'b0;
            m_newd_q      <= 1'b0;
            m_addr_q      <= '0;
            m_op_q        <= 1'b0;
            m_din_q       <= '0;
            fault_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Fields are latched here so requesters may change them once granted.
                    if (pick_any && !m_busy) begin
                        idx_q    <= pick_idx;
                        gnt_q    <= pick_winner;
                        m_newd_q <= 1'b1;
                        m_addr_q <= req_addr[int'(pick_idx)*I2C_ADDR_W +: I2C_ADDR_W];
                        m_op_q   <= req_op[pick_idx];
                        m_din_q  <= req_wdata[int'(pick_idx)*I2C_DATA_W +: I2C_DATA_W];
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    gnt_q    <= '0;
                    m_newd_q <= 1'b0;
                    wd_q     <= '0;
                    state_q  <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    // A done coinciding with watchdog expiry is treated as a normal completion.
                    if (m_done) begin
                        rsp_rdata_q   <= m_dout;
                        rsp_ack_err_q <= m_ack_err;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= NUM_REQ'(1) << idx_q;
                        state_q       <= ST_RESP;
                    end else if (wd_expired) begin
                        rsp_rdata_q   <= '0;
                        rsp_ack_err_q <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        fault_q       <= 1'b1;
                        rsp_valid_q   <= NUM_REQ'(1) << idx_q;
                        state_q       <= ST_RESP;
                    end else begin
                        wd_q <= wd_d;
                    end
                end
                ST_RESP: begin
                    rsp_valid_q <= '0;
                    last_gnt_q  <= idx_q;
                    wd_q        <= '0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_ack_err = rsp_ack_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign m_newd      = m_newd_q;
    assign m_addr      = m_addr_q;
    assign m_op        = m_op_q;
    assign m_din       = m_din_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: vector table plus hand-written sequences,
// with a scoreboard queue of expected responses and an inline i2c master model.
module tb_i2c_bus_arbiter;
    import i2c_pkg::*;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 100;

    typedef struct {
        int         idx;
        logic [6:0] addr;
        logic       op;
        logic [7:0] wdata;
        int         dly;
        logic [7:0] dout;
        logic       ackErr;
        logic [7:0] expRdata;
        logic       expAck;
        logic       expTo;
        logic       expFault;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [7*NREQ-1:0]   req_addr = '0;
    logic [NREQ-1:0]     req_op = '0;
    logic [8*NREQ-1:0]   req_wdata = '0;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     rsp_valid;
    logic [7:0]          rsp_rdata;
    logic                rsp_ack_err;
    logic                rsp_timeout;
    logic                m_newd;
    logic [6:0]          m_addr;
    logic                m_op;
    logic [7:0]          m_din;
    logic                m_busy = 1'b0;
    logic                m_done = 1'b0;
    logic                m_ack_err = 1'b0;
    logic [7:0]          m_dout = '0;
    logic                fault;

    int   vectors = 0;
    int   miscompares = 0;
    int   lastModel;
    vec_t sb[$];
    vec_t tbl[6];
    vec_t cv[2];
    vec_t rv[2];
    vec_t bv;

    i2c_bus_arbiter #(
        .NUM_REQ        (NREQ),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_addr    (req_addr),
        .req_op      (req_op),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_ack_err (rsp_ack_err),
        .rsp_timeout (rsp_timeout),
        .m_newd      (m_newd),
        .m_addr      (m_addr),
        .m_op        (m_op),
        .m_din       (m_din),
        .m_busy      (m_busy),
        .m_done      (m_done),
        .m_ack_err   (m_ack_err),
        .m_dout      (m_dout),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL global_time_limit: got expired expected finish");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int rrNext(input logic [NREQ-1:0] mask, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic checkAllZero(input string tag);
        compare({tag, "_gnt"}, 32'(gnt), 0);
        compare({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        compare({tag, "_rsp_rdata"}, 32'(rsp_rdata), 0);
        compare({tag, "_rsp_ack_err"}, 32'(rsp_ack_err), 0);
        compare({tag, "_rsp_timeout"}, 32'(rsp_timeout), 0);
        compare({tag, "_m_newd"}, 32'(m_newd), 0);
        compare({tag, "_m_addr"}, 32'(m_addr), 0);
        compare({tag, "_m_op"}, 32'(m_op), 0);
        compare({tag, "_m_din"}, 32'(m_din), 0);
        compare({tag, "_fault"}, 32'(fault), 0);
    endtask

    task automatic applyStimulus(input vec_t v, input bit push);
        req[v.idx]              = 1'b1;
        req_addr[v.idx*7 +: 7]  = v.addr;
        req_op[v.idx]           = v.op;
        req_wdata[v.idx*8 +: 8] = v.wdata;
        if (push) sb.push_back(v);
    endtask

    task automatic checkOutput(input bit dropReq);
        vec_t e;
        int   lat;
        int   cyc;
        int   extra;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries expected at least 1");
            return;
        end
        e = sb.pop_front();
        m_dout = e.dout;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (gnt == '0 && lat < 50);
        compare("gnt_latency", lat, 1);
        compare("gnt_onehot", 32'(gnt), 32'(1) << e.idx);
        compare("issue_m_newd", 32'(m_newd), 1);
        compare("issue_m_addr", 32'(m_addr), 32'(e.addr));
        compare("issue_m_op", 32'(m_op), 32'(e.op));
        compare("issue_m_din", 32'(m_din), 32'(e.wdata));
        if (gnt == '0) return;
        if (dropReq) begin
            req[e.idx]              = 1'b0;
            req_addr[e.idx*7 +: 7]  = ~e.addr;
            req_op[e.idx]           = ~e.op;
            req_wdata[e.idx*8 +: 8] = ~e.wdata;
        end
        extra = 0;
        if (e.dly >= 0) begin
            repeat (e.dly) begin
                @(posedge clk); #1;
                if (m_newd || rsp_valid != '0) extra++;
            end
            @(negedge clk);
            m_done    = 1'b1;
            m_ack_err = e.ackErr;
            @(posedge clk); #1;
        end else begin
            cyc = 0;
            do begin
                @(posedge clk); #1;
                cyc++;
                if (m_newd) extra++;
            end while (rsp_valid == '0 && cyc < TIMEOUT + 20);
            compare("timeout_cycles", cyc, TIMEOUT + 1);
        end
        compare("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
        compare("rsp_rdata", 32'(rsp_rdata), 32'(e.expRdata));
        compare("rsp_ack_err", 32'(rsp_ack_err), 32'(e.expAck));
        compare("rsp_timeout", 32'(rsp_timeout), 32'(e.expTo));
        compare("fault", 32'(fault), 32'(e.expFault));
        compare("resp_m_addr", 32'(m_addr), 32'(e.addr));
        compare("resp_m_din", 32'(m_din), 32'(e.wdata));
        compare("stray_newd_or_rsp", extra, 0);
        @(negedge clk);
        m_done    = 1'b0;
        m_ack_err = 1'b0;
        @(posedge clk); #1;
        compare("rsp_pulse_end", 32'(rsp_valid), 0);
        lastModel = e.idx;
    endtask

    initial begin
        int   w;
        int   lat;
        bit   bad;
        logic [NREQ-1:0] mask;

        tbl[0] = '{0, 7'h50, OP_WRITE, 8'hA5, 50,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1, 7'h3C, OP_READ,  8'h00, 20,  8'h7E, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{0, 7'h12, OP_READ,  8'h5A, 2,   8'hC3, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1, 7'h7F, OP_WRITE, 8'hFF, 1,   8'h11, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{0, 7'h01, OP_READ,  8'h00, 100, 8'h99, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1, 7'h22, OP_READ,  8'h00, -1,  8'hEE, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        cv[0]  = '{0, 7'h0A, OP_WRITE, 8'h11, 3,   8'h21, 1'b0, 8'h21, 1'b0, 1'b0, 1'b0};
        cv[1]  = '{1, 7'h0B, OP_READ,  8'h22, 4,   8'h42, 1'b1, 8'h42, 1'b1, 1'b0, 1'b0};
        bv     = '{0, 7'h2D, OP_WRITE, 8'h3C, 5,   8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        rv[0]  = '{0, 7'h44, OP_READ,  8'h00, 6,   8'hAB, 1'b0, 8'hAB, 1'b0, 1'b0, 1'b0};
        rv[1]  = '{1, 7'h45, OP_WRITE, 8'h6D, 7,   8'hCD, 1'b1, 8'hCD, 1'b1, 1'b0, 1'b0};

        $display("[TB] reset state");
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;
        lastModel = NREQ - 1;

        $display("[TB] contention: both requesters held for four transfers");
        applyStimulus(cv[0], 1'b0);
        applyStimulus(cv[1], 1'b0);
        for (int k = 0; k < 4; k++) begin
            w = rrNext(2'b11, lastModel);
            sb.push_back(cv[w]);
            lastModel = w;
        end
        for (int k = 0; k < 4; k++) begin
            checkOutput(1'b0);
        end
        req = '0;

        $display("[TB] vector table");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            applyStimulus(tbl[i], 1'b1);
            checkOutput(1'b1);
        end

        $display("[TB] late done after timeout");
        @(negedge clk);
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        bad = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid != '0 || gnt != '0 || m_newd) bad = 1'b1;
        end
        compare("late_done_ignored", 32'(bad), 0);
        compare("fault_sticky", 32'(fault), 1);

        $display("[TB] busy gating");
        @(negedge clk);
        m_busy = 1'b1;
        applyStimulus(bv, 1'b1);
        bad = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (gnt != '0 || m_newd) bad = 1'b1;
        end
        compare("busy_blocks_grant", 32'(bad), 0);
        @(negedge clk);
        m_busy = 1'b0;
        checkOutput(1'b1);

        $display("[TB] async reset during WAIT_DONE");
        @(negedge clk);
        applyStimulus(rv[0], 1'b0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (gnt == '0 && lat < 50);
        compare("rst_pre_gnt", 32'(gnt), 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkAllZero("async_rst");
        applyStimulus(rv[0], 1'b0);
        applyStimulus(rv[1], 1'b0);
        bad = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (rsp_valid != '0 || gnt != '0 || m_newd) bad = 1'b1;
        end
        compare("rst_hold_quiet", 32'(bad), 0);
        @(negedge clk);
        rst = 1'b0;
        lastModel = NREQ - 1;
        mask = 2'b11;
        w = rrNext(mask, lastModel);
        sb.push_back(rv[w]);
        mask[w] = 1'b0;
        w = rrNext(mask, w);
        sb.push_back(rv[w]);
        checkOutput(1'b1);
        checkOutput(1'b1);

        compare("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
